// File: rtl/branch_predictor.sv
// Direct-mapped BHT/BTB. Each entry holds a 2-bit saturating counter and a target.
// Lookup is combinational at fetch. Update happens at EX when the branch or jump resolves.
module bp_entry #(
    parameter int TAG_W = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             upd_sel,
    input  logic [TAG_W-1:0] tag_in,
    input  logic [31:0]      target_in,
    input  logic             taken,
    input  logic             jump,
    output logic             valid,
    output logic [TAG_W-1:0] tag,
    output logic [31:0]      target,
    output logic [1:0]       ctr
);
    logic hit;
    assign hit = valid && (tag == tag_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid  <= 1'b0;
            tag    <= '0;
            target <= '0;
            ctr    <= 2'b01;
        end else if (upd_sel) begin
            if (hit) begin
                if (jump)
                    ctr <= 2'b11;
                else if (taken)
                    ctr <= (ctr == 2'b11) ? ctr : ctr + 2'b01;
                else
                    ctr <= (ctr == 2'b00) ? ctr : ctr - 2'b01;
                if (taken)
                    target <= target_in;
            end else if (taken) begin
                // Allocate on a miss. Any other branch that aliases to this slot is evicted.
                valid  <= 1'b1;
                tag    <= tag_in;
                target <= target_in;
                ctr    <= jump ? 2'b11 : 2'b10;
            end
        end
    end
endmodule

module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_F,
    output logic        taken_F,
    output logic [31:0] target_F,
    input  logic        StallE,
    input  logic        branch_E,
    input  logic        jump_E,
    input  logic [31:0] pc_E,
    input  logic [31:0] pc4_E,
    input  logic        takenE,
    input  logic [31:0] pred_target_E,
    input  logic        actual_taken_E,
    input  logic [31:0] actual_target_E,
    output logic        mispredict_E,
    output logic [31:0] redirect_pc_E,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);
    localparam int TAG_W = 32 - IDX_W - 2;

    logic [ENTRIES-1:0]            valid_q;
    logic [ENTRIES-1:0][TAG_W-1:0] tag_q;
    logic [ENTRIES-1:0][31:0]      target_q;
    logic [ENTRIES-1:0][1:0]       ctr_q;

    logic [IDX_W-1:0] idx_F, idx_E;
    logic [TAG_W-1:0] tag_F, tag_E;
    logic             hit_F, upd;
    logic             unused_pc_bits;

    assign idx_F = pc_F[IDX_W+1:2];
    assign tag_F = pc_F[31:IDX_W+2];
    assign idx_E = pc_E[IDX_W+1:2];
    assign tag_E = pc_E[31:IDX_W+2];
    assign unused_pc_bits = ^{pc_F[1:0], pc_E[1:0]};

    assign upd = (branch_E || jump_E) && !StallE;

    for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
        bp_entry #(.TAG_W(TAG_W)) u_ent (
            .clk       (clk),
            .rst_n     (rst_n),
            .upd_sel   (upd && (idx_E == IDX_W'(i))),
            .tag_in    (tag_E),
            .target_in (actual_target_E),
            .taken     (actual_taken_E),
            .jump      (jump_E),
            .valid     (valid_q[i]),
            .tag       (tag_q[i]),
            .target    (target_q[i]),
            .ctr       (ctr_q[i])
        );
    end

    // Registered state is read here, so an update in the same cycle shows up one cycle later.
    assign hit_F    = valid_q[idx_F] && (tag_q[idx_F] == tag_F);
    assign taken_F  = hit_F && ctr_q[idx_F][1];
    assign target_F = hit_F ? target_q[idx_F] : pc_F + 32'd4;

    assign mispredict_E = (branch_E || jump_E) &&
                          ((actual_taken_E != takenE) ||
                           (actual_taken_E && takenE && (actual_target_E != pred_target_E)));
    assign redirect_pc_E = actual_taken_E ? actual_target_E : pc4_E;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (upd) begin
            if (branch_count != 32'hFFFF_FFFF)
                branch_count <= branch_count + 32'd1;
            if (mispredict_E && (mispredict_count != 32'hFFFF_FFFF))
                mispredict_count <= mispredict_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed test for branch_predictor. Every expected value is worked out by hand.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_F;
    logic        taken_F;
    logic [31:0] target_F;
    logic        StallE, branch_E, jump_E, takenE, actual_taken_E;
    logic [31:0] pc_E, pc4_E, pred_target_E, actual_target_E;
    logic        mispredict_E;
    logic [31:0] redirect_pc_E, branch_count, mispredict_count;

    int n_chk = 0;
    int n_pass = 0;

    branch_predictor dut (
        .clk(clk), .rst_n(rst_n), .pc_F(pc_F), .taken_F(taken_F), .target_F(target_F),
        .StallE(StallE), .branch_E(branch_E), .jump_E(jump_E), .pc_E(pc_E), .pc4_E(pc4_E),
        .takenE(takenE), .pred_target_E(pred_target_E), .actual_taken_E(actual_taken_E),
        .actual_target_E(actual_target_E), .mispredict_E(mispredict_E),
        .redirect_pc_E(redirect_pc_E), .branch_count(branch_count),
        .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic ex(input logic br, input logic jmp, input logic [31:0] pc,
                      input logic pt, input logic [31:0] ptgt,
                      input logic at, input logic [31:0] atgt);
        branch_E = br; jump_E = jmp; pc_E = pc; pc4_E = pc + 32'd4;
        takenE = pt; pred_target_E = ptgt; actual_taken_E = at; actual_target_E = atgt;
    endtask

    task automatic idle;
        ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Pass one rising edge, then return on the following falling edge.
    task automatic step;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; StallE = 1'b0; pc_F = 32'h100;
        idle();
        #1;
        chk("rst_taken", 32'(taken_F), 32'h0);
        chk("rst_target", target_F, 32'h104);
        chk("rst_bcnt", branch_count, 32'h0);
        chk("rst_mcnt", mispredict_count, 32'h0);

        @(negedge clk); rst_n = 1'b1;
        // First allocate 0x100 -> 0x80. A lookup in the same cycle still sees the old entry.
        ex(1'b1, 1'b0, 32'h100, 1'b0, 32'h104, 1'b1, 32'h80);
        #1;
        chk("alloc_misp", 32'(mispredict_E), 32'h1);
        chk("alloc_redir", redirect_pc_E, 32'h80);
        chk("same_cyc_taken", 32'(taken_F), 32'h0);
        step(); idle(); #1;
        chk("next_taken", 32'(taken_F), 32'h1);
        chk("next_target", target_F, 32'h80);
        chk("bcnt1", branch_count, 32'h1);
        chk("mcnt1", mispredict_count, 32'h1);
        chk("ctr_alloc", 32'(dut.ctr_q[0]), 32'h2);

        // Three more taken resolutions saturate the counter at 11.
        for (int k = 0; k < 3; k++) begin
            ex(1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
            #1; chk("tk_nomisp", 32'(mispredict_E), 32'h0);
            step(); idle(); #1;
            chk("ctr_tk", 32'(dut.ctr_q[0]), 32'h3);
        end
        ex(1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h80);
        #1;
        chk("nt_misp", 32'(mispredict_E), 32'h1);
        chk("nt_redir", redirect_pc_E, 32'h104);
        step(); idle(); #1;
        chk("ctr_nt", 32'(dut.ctr_q[0]), 32'h2);
        chk("nt_taken", 32'(taken_F), 32'h1);
        chk("bcnt5", branch_count, 32'h5);
        chk("mcnt2", mispredict_count, 32'h2);

        // A stalled branch must leave the table and counters untouched.
        StallE = 1'b1;
        ex(1'b1, 1'b0, 32'h140, 1'b0, 32'h144, 1'b1, 32'h200);
        #1;
        chk("stall_misp", 32'(mispredict_E), 32'h1);
        chk("stall_redir", redirect_pc_E, 32'h200);
        step(); #1;
        chk("stall_bcnt", branch_count, 32'h5);
        chk("stall_mcnt", mispredict_count, 32'h2);
        chk("stall_tgt100", target_F, 32'h80);
        pc_F = 32'h140; #1;
        chk("stall_tk140", 32'(taken_F), 32'h0);

        // 0x140 maps to the same slot as 0x100 and evicts it.
        StallE = 1'b0;
        step(); idle(); #1;
        chk("conf_tk140", 32'(taken_F), 32'h1);
        chk("conf_tgt140", target_F, 32'h200);
        pc_F = 32'h100; #1;
        chk("conf_tk100", 32'(taken_F), 32'h0);
        chk("conf_tgt100", target_F, 32'h104);
        chk("bcnt6", branch_count, 32'h6);

        // A not-taken branch that misses the table does not allocate.
        ex(1'b1, 1'b0, 32'h104, 1'b0, 32'h108, 1'b0, 32'h0);
        pc_F = 32'h104; #1;
        chk("ntmiss_misp", 32'(mispredict_E), 32'h0);
        step(); idle(); #1;
        chk("ntmiss_tk", 32'(taken_F), 32'h0);
        chk("ntmiss_tgt", target_F, 32'h108);
        chk("bcnt7", branch_count, 32'h7);
        chk("mcnt3", mispredict_count, 32'h3);

        // A jal allocates with the counter already at 11.
        ex(1'b0, 1'b1, 32'h108, 1'b0, 32'h10C, 1'b1, 32'h300);
        #1; chk("jal_misp", 32'(mispredict_E), 32'h1);
        step(); idle(); pc_F = 32'h108; #1;
        chk("jal_ctr", 32'(dut.ctr_q[2]), 32'h3);
        chk("jal_tgt", target_F, 32'h300);

        // Direction predicted correctly but target wrong still counts as a mispredict.
        ex(1'b1, 1'b0, 32'h140, 1'b1, 32'h200, 1'b1, 32'h240);
        #1;
        chk("tgt_misp", 32'(mispredict_E), 32'h1);
        chk("tgt_redir", redirect_pc_E, 32'h240);
        step(); idle(); pc_F = 32'h140; #1;
        chk("tgt_new", target_F, 32'h240);
        chk("bcnt9", branch_count, 32'h9);
        chk("mcnt5", mispredict_count, 32'h5);

        // Reset wins over an update that is pending at the same time.
        ex(1'b1, 1'b0, 32'h140, 1'b0, 32'h144, 1'b1, 32'h500);
        rst_n = 1'b0; #1;
        chk("mrst_tk", 32'(taken_F), 32'h0);
        chk("mrst_tgt", target_F, 32'h144);
        chk("mrst_bcnt", branch_count, 32'h0);
        step(); #1;
        chk("mrst_hold", mispredict_count, 32'h0);
        rst_n = 1'b1;
        step(); idle(); #1;
        chk("post_rst_tgt", target_F, 32'h500);
        chk("post_rst_mcnt", mispredict_count, 32'h1);

        // A saturated mispredict counter must not wrap to zero.
        force dut.mispredict_count = 32'hFFFF_FFFF;
        #1;
        release dut.mispredict_count;
        ex(1'b1, 1'b0, 32'h100, 1'b0, 32'h104, 1'b1, 32'h80);
        step(); idle(); #1;
        chk("sat_mcnt", mispredict_count, 32'hFFFF_FFFF);
        chk("sat_bcnt", branch_count, 32'h2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
